tawas_thread_sched: RTL and testbench

Parametrised barrel-thread scheduler for the next-generation Tawas core. It replaces the fixed 4-slice rotation with a THREADS-wide rotation. It adds per-thread run/halt/sleep state, event wake-up with a pending latch, stall gating, and per-thread saturating issue counters. It sits beside fetch and drives slice/issue-valid to fetch, AU, LS, RCN and the regfile.

---
 rtl/tawas_thread_sched.sv | 154 +++++++++++++++
 tb/tb_tawas_thread_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tawas_thread_sched.sv
// Barrel-thread scheduler: fixed THREADS-wide slot rotation with per-thread
// HALT/RUN/SLEEP state, event wake-up with pending latch, stall gating and issue counters.
module tawas_thread_sched #(
    parameter int unsigned         THREADS        = 4,
    parameter int unsigned         SLICE_W        = 2,
    parameter logic [THREADS-1:0]  RESET_RUN_MASK = THREADS'(1),
    parameter int unsigned         CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [THREADS-1:0] thread_stall,
    input  logic               halt_vld,
    input  logic [SLICE_W-1:0] halt_id,
    input  logic               wake_vld,
    input  logic [SLICE_W-1:0] wake_id,
    input  logic               sleep_vld,
    input  logic [SLICE_W-1:0] sleep_id,
    input  logic [THREADS-1:0] evt,
    input  logic               cnt_clr_vld,
    input  logic [SLICE_W-1:0] cnt_clr_id,
    input  logic [SLICE_W-1:0] cnt_rd_sel,
    output logic [SLICE_W-1:0] slice,
    output logic               slice_vld,
    output logic [THREADS-1:0] run_mask,
    output logic [THREADS-1:0] sleep_mask,
    output logic               all_idle,
    output logic [CNT_W-1:0]   cnt_rd_data
);

    localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(THREADS - 1);

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SLEEP = 2'd2
    } thr_st_e;

    thr_st_e            st_q [THREADS];
    thr_st_e            st_d [THREADS];
    logic [THREADS-1:0] pend_q;
    logic [THREADS-1:0] pend_d;
    logic [CNT_W-1:0]   cnt_q [THREADS];

    logic [SLICE_W-1:0] ns_c;
    logic               issue_c;
    logic [CNT_W-1:0]   rd_c;
    logic [THREADS-1:0] halt_sel;
    logic [THREADS-1:0] wake_sel;
    logic [THREADS-1:0] sleep_sel;
    logic [THREADS-1:0] clr_sel;

    // Next slot and its issue eligibility; also the counter read mux (out-of-range reads 0)
    always_comb begin
        ns_c    = (slice == LAST_SLICE) ? '0 : slice + SLICE_W'(1);
        issue_c = 1'b0;
        rd_c    = '0;
        for (int unsigned t = 0; t < THREADS; t++) begin
            if (ns_c == SLICE_W'(t)) begin
                issue_c = (st_q[t] == ST_RUN) && !thread_stall[t];
            end
            if (cnt_rd_sel == SLICE_W'(t)) begin
                rd_c = cnt_q[t];
            end
        end
    end

    // Request id decode; ids >= THREADS match nothing and are thereby ignored
    always_comb begin
        halt_sel  = '0;
        wake_sel  = '0;
        sleep_sel = '0;
        clr_sel   = '0;
        for (int unsigned t = 0; t < THREADS; t++) begin
            halt_sel[t]  = halt_vld    && (halt_id    == SLICE_W'(t));
            wake_sel[t]  = wake_vld    && (wake_id    == SLICE_W'(t));
            sleep_sel[t] = sleep_vld   && (sleep_id   == SLICE_W'(t));
            clr_sel[t]   = cnt_clr_vld && (cnt_clr_id == SLICE_W'(t));
        end
    end

    // Per-thread state transitions: halt > sleep > wake > evt
    always_comb begin
        pend_d = pend_q;
        for (int unsigned t = 0; t < THREADS; t++) begin
            st_d[t] = st_q[t];
            if (halt_sel[t]) begin
                st_d[t]   = ST_HALT;
                pend_d[t] = 1'b0;
            end else begin
                unique case (st_q[t])
                    ST_RUN: begin
                        // A same-cycle event counts as pending and absorbs the sleep
                        if (sleep_sel[t]) begin
                            if (pend_q[t] || evt[t]) begin
                                pend_d[t] = 1'b0;
                            end else begin
                                st_d[t] = ST_SLEEP;
                            end
                        end else if (evt[t]) begin
                            pend_d[t] = 1'b1;
                        end
                    end
                    ST_HALT: begin
                        if (wake_sel[t]) begin
                            st_d[t] = ST_RUN;
                        end
                    end
                    ST_SLEEP: begin
                        if (wake_sel[t] || evt[t]) begin
                            st_d[t] = ST_RUN;
                        end
                    end
                    default: st_d[t] = ST_HALT;
                endcase
            end
        end
    end

    always_comb begin
        for (int unsigned t = 0; t < THREADS; t++) begin
            run_mask[t]   = (st_q[t] == ST_RUN);
            sleep_mask[t] = (st_q[t] == ST_SLEEP);
        end
        all_idle = ~|run_mask;
    end

    // Rotation, issue valid, thread state and saturating issue counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slice       <= LAST_SLICE;
            slice_vld   <= 1'b0;
            cnt_rd_data <= '0;
            pend_q      <= '0;
            for (int unsigned t = 0; t < THREADS; t++) begin
                st_q[t]  <= RESET_RUN_MASK[t] ? ST_RUN : ST_HALT;
                cnt_q[t] <= '0;
            end
        end else begin
            slice       <= ns_c;
            slice_vld   <= issue_c;
            cnt_rd_data <= rd_c;
            pend_q      <= pend_d;
            for (int unsigned t = 0; t < THREADS; t++) begin
                st_q[t] <= st_d[t];
                if (clr_sel[t]) begin
                    cnt_q[t] <= '0;
                end else if (slice_vld && (slice == SLICE_W'(t)) && (cnt_q[t] != '1)) begin
                    cnt_q[t] <= cnt_q[t] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tawas_thread_sched.sv
// Scoreboard bench for tawas_thread_sched: a behavioural model queues the expected
// outputs for every edge; a second narrow-counter instance covers saturation and id range.
module tb_tawas_thread_sched;

    localparam int unsigned NT  = 4;
    localparam int unsigned SW  = 2;
    localparam int unsigned CW  = 32;
    localparam int unsigned NT2 = 2;
    localparam int unsigned SW2 = 2;
    localparam int unsigned CW2 = 4;

    localparam int ST_HALT  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_SLEEP = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic          rst;
    logic [NT-1:0] stall;
    logic          halt_vld, wake_vld, sleep_vld, clr_vld;
    logic [SW-1:0] halt_id, wake_id, sleep_id, clr_id, rd_sel;
    logic [NT-1:0] evt;
    logic [SW-1:0] slice;
    logic          slice_vld;
    logic [NT-1:0] run_mask, sleep_mask;
    logic          all_idle;
    logic [CW-1:0] rd_data;

    // narrow instance
    logic           rst2;
    logic           halt_vld2, clr_vld2;
    logic [SW2-1:0] halt_id2, clr_id2, rd_sel2;
    logic [SW2-1:0] slice2;
    logic           slice_vld2;
    logic [NT2-1:0] run_mask2, sleep_mask2;
    logic           all_idle2;
    logic [CW2-1:0] rd_data2;

    tawas_thread_sched #(.THREADS(NT), .SLICE_W(SW), .RESET_RUN_MASK(4'b0001), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .thread_stall(stall),
        .halt_vld(halt_vld), .halt_id(halt_id),
        .wake_vld(wake_vld), .wake_id(wake_id),
        .sleep_vld(sleep_vld), .sleep_id(sleep_id),
        .evt(evt), .cnt_clr_vld(clr_vld), .cnt_clr_id(clr_id), .cnt_rd_sel(rd_sel),
        .slice(slice), .slice_vld(slice_vld), .run_mask(run_mask), .sleep_mask(sleep_mask),
        .all_idle(all_idle), .cnt_rd_data(rd_data)
    );

    tawas_thread_sched #(.THREADS(NT2), .SLICE_W(SW2), .RESET_RUN_MASK(2'b01), .CNT_W(CW2)) dut2 (
        .clk(clk), .rst(rst2), .thread_stall(2'b00),
        .halt_vld(halt_vld2), .halt_id(halt_id2),
        .wake_vld(1'b0), .wake_id(2'd0),
        .sleep_vld(1'b0), .sleep_id(2'd0),
        .evt(2'b00), .cnt_clr_vld(clr_vld2), .cnt_clr_id(clr_id2), .cnt_rd_sel(rd_sel2),
        .slice(slice2), .slice_vld(slice_vld2), .run_mask(run_mask2), .sleep_mask(sleep_mask2),
        .all_idle(all_idle2), .cnt_rd_data(rd_data2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int e2      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [SW-1:0] slice;
        logic          vld;
        logic [NT-1:0] run;
        logic [NT-1:0] slp;
        logic          idle;
        logic [CW-1:0] rd;
    } exp_t;

    exp_t sb[$];

    // reference model state
    int            mst [NT];
    bit            mpend [NT];
    int            mslice;
    bit            mvld;
    logic [CW-1:0] mcnt [NT];
    logic [CW-1:0] mrd;

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            mst[t]   = (t == 0) ? ST_RUN : ST_HALT;
            mpend[t] = 1'b0;
            mcnt[t]  = '0;
        end
        mslice = NT - 1;
        mvld   = 1'b0;
        mrd    = '0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.slice = SW'(mslice);
        e.vld   = mvld;
        e.run   = '0;
        e.slp   = '0;
        for (int t = 0; t < NT; t++) begin
            e.run[t] = (mst[t] == ST_RUN);
            e.slp[t] = (mst[t] == ST_SLEEP);
        end
        e.idle = (e.run == '0);
        e.rd   = mrd;
        return e;
    endfunction

    // one clock edge of the model, using the inputs currently driven
    task automatic model_edge();
        int ns;
        bit nv;
        bit h, s, w, ev;
        ns  = (mslice == NT - 1) ? 0 : mslice + 1;
        nv  = (mst[ns] == ST_RUN) && !stall[ns];
        mrd = (int'(rd_sel) < NT) ? mcnt[rd_sel] : '0;
        for (int t = 0; t < NT; t++) begin
            if (clr_vld && int'(clr_id) == t) mcnt[t] = '0;
            else if (mvld && mslice == t && mcnt[t] != '1) mcnt[t] = mcnt[t] + 1;
        end
        for (int t = 0; t < NT; t++) begin
            h  = halt_vld  && int'(halt_id)  == t;
            s  = sleep_vld && int'(sleep_id) == t;
            w  = wake_vld  && int'(wake_id)  == t;
            ev = evt[t];
            if (h) begin
                mst[t]   = ST_HALT;
                mpend[t] = 1'b0;
            end else if (mst[t] == ST_RUN) begin
                if (s) begin
                    if (mpend[t] || ev) mpend[t] = 1'b0;
                    else mst[t] = ST_SLEEP;
                end else if (ev) begin
                    mpend[t] = 1'b1;
                end
            end else if (mst[t] == ST_HALT) begin
                if (w) mst[t] = ST_RUN;
            end else begin
                if (w || ev) mst[t] = ST_RUN;
            end
        end
        mslice = ns;
        mvld   = nv;
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(1), 32'(0));
            return;
        end
        e = sb.pop_front();
        check("slice",      32'(slice),      32'(e.slice));
        check("slice_vld",  32'(slice_vld),  32'(e.vld));
        check("run_mask",   32'(run_mask),   32'(e.run));
        check("sleep_mask", 32'(sleep_mask), 32'(e.slp));
        check("all_idle",   32'(all_idle),   32'(e.idle));
        check("cnt_rd",     32'(rd_data),    32'(e.rd));
    endtask

    // advance one edge: queue the model's prediction, then compare after the edge
    task automatic step();
        model_edge();
        sb.push_back(model_out());
        @(posedge clk);
        #1;
        e2++;
        compare_out();
    endtask

    task automatic idle();
        halt_vld = 1'b0; wake_vld = 1'b0; sleep_vld = 1'b0; clr_vld = 1'b0;
        evt = '0;
    endtask

    task automatic check_reset_main(input string tag);
        check({tag, "_slice"},  32'(slice),      32'(3));
        check({tag, "_vld"},    32'(slice_vld),  32'(0));
        check({tag, "_run"},    32'(run_mask),   32'(4'b0001));
        check({tag, "_sleep"},  32'(sleep_mask), 32'(0));
        check({tag, "_idle"},   32'(all_idle),   32'(0));
        check({tag, "_rd"},     32'(rd_data),    32'(0));
    endtask

    initial begin
        rst = 1'b0; rst2 = 1'b0;
        stall = '0; idle();
        halt_id = '0; wake_id = '0; sleep_id = '0; clr_id = '0; rd_sel = '0;
        halt_vld2 = 1'b0; halt_id2 = '0; clr_vld2 = 1'b0; clr_id2 = '0; rd_sel2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_main("rst");
        check("rst2_slice", 32'(slice2),   32'(1));
        check("rst2_run",   32'(run_mask2), 32'(2'b01));
        model_reset();
        rst = 1'b1; rst2 = 1'b1;

        // free rotation, only thread 0 runs
        repeat (9) step();
        check("cnt0_after8", 32'(rd_data), 32'(2));
        check("dut2_cnt_early", 32'(rd_data2), 32'(4));

        // wake thread 2
        wake_vld = 1'b1; wake_id = 2'd2;
        step(); idle();
        check("wake2_run", 32'(run_mask), 32'(4'b0101));
        repeat (6) step();

        // pending event absorbs one sleep; second sleep parks the thread
        halt_vld = 1'b1; halt_id = 2'd2; step(); idle();
        evt = 4'b0001; step(); idle();
        sleep_vld = 1'b1; sleep_id = 2'd0; step(); idle();
        check("pend_absorb", 32'(run_mask), 32'(4'b0001));
        sleep_vld = 1'b1; sleep_id = 2'd0; step(); idle();
        check("sleep_mask0", 32'(sleep_mask), 32'(4'b0001));
        check("all_idle1",   32'(all_idle),   32'(1));
        repeat (4) step();
        evt = 4'b0001; step(); idle();
        check("evt_wake", 32'(run_mask), 32'(4'b0001));

        // halt beats wake; sleep with same-cycle event stays RUN with pending clear
        wake_vld = 1'b1; wake_id = 2'd1; step(); idle();
        check("wake1", 32'(run_mask), 32'(4'b0011));
        halt_vld = 1'b1; halt_id = 2'd1; wake_vld = 1'b1; wake_id = 2'd1; step(); idle();
        check("halt_wins", 32'(run_mask), 32'(4'b0001));
        sleep_vld = 1'b1; sleep_id = 2'd0; evt = 4'b0001; step(); idle();
        check("sleep_evt", 32'(run_mask), 32'(4'b0001));
        sleep_vld = 1'b1; sleep_id = 2'd0; step(); idle();
        check("pend_cleared", 32'(sleep_mask), 32'(4'b0001));
        evt = 4'b0001; step(); idle();
        repeat (3) step();

        // stall thread 0 for three rotations, then release
        stall = 4'b0001; rd_sel = 2'd0;
        repeat (12) step();
        stall = '0;
        repeat (8) step();

        // randomised traffic
        for (int i = 0; i < 300; i++) begin
            halt_vld  = ($urandom_range(0, 9) == 0);
            halt_id   = SW'($urandom_range(0, 3));
            wake_vld  = ($urandom_range(0, 2) == 0);
            wake_id   = SW'($urandom_range(0, 3));
            sleep_vld = ($urandom_range(0, 5) == 0);
            sleep_id  = SW'($urandom_range(0, 3));
            evt       = NT'($urandom_range(0, 15) & $urandom_range(0, 15));
            stall     = NT'($urandom_range(0, 15) & $urandom_range(0, 15));
            clr_vld   = ($urandom_range(0, 7) == 0);
            clr_id    = SW'($urandom_range(0, 3));
            rd_sel    = SW'($urandom_range(0, 3));
            step();
        end
        idle(); stall = '0;

        // narrow instance: saturation, clear vs increment, out-of-range ids
        step();
        check("sat15", 32'(rd_data2), 32'(15));
        if (e2 % 2 == 0) step();
        clr_vld2 = 1'b1; clr_id2 = 2'd0; step(); clr_vld2 = 1'b0;
        check("rd_pre_clear", 32'(rd_data2), 32'(15));
        step();
        check("clr_beats_inc", 32'(rd_data2), 32'(0));
        rd_sel2 = 2'd2; step();
        check("rd_oor", 32'(rd_data2), 32'(0));
        halt_vld2 = 1'b1; halt_id2 = 2'd3; step(); halt_vld2 = 1'b0;
        check("halt_oor", 32'(run_mask2), 32'(2'b01));
        halt_vld2 = 1'b1; halt_id2 = 2'd0; step(); halt_vld2 = 1'b0;
        check("halt2_idle", 32'(all_idle2), 32'(1));

        // reset mid-operation with requests in flight
        wake_vld = 1'b1; wake_id = 2'd3; evt = 4'b1111; clr_vld = 1'b1;
        rst = 1'b0;
        #1;
        check_reset_main("midrst");
        @(posedge clk);
        #1;
        check_reset_main("midrst_hold");
        idle();
        model_reset();
        rst = 1'b1;
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
